// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store sequencer in front of data_memory: checks each request,
// drives one registered access, waits out mem_busy and hands load data to writeback.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [2:0]  load_type,
    output logic [2:0]  store_type,
    output logic [31:0] ram_address,
    output logic [31:0] data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy,
    output logic        stall_req,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic             is_load_q, is_load_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_en_q, wr_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kill_q, kill_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic req;
    logic req_load;
    logic f3_legal;
    logic misalign;
    logic accept;

    // Handshake: EX raises ex_valid with a read/write kind; the request is taken in
    // that same cycle when it is legal and not flushed, and stall_req then stays high
    // until the op retires. Rejected requests raise err_valid instead and never stall.
    always_comb begin
        req      = ex_valid && (ex_mem_read || ex_mem_write) && !flush;
        req_load = ex_mem_read;
        if (req_load) begin
            f3_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) ||
                       (ex_funct3 == 3'b010) || (ex_funct3 == 3'b100) ||
                       (ex_funct3 == 3'b101);
        end else begin
            f3_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) ||
                       (ex_funct3 == 3'b010);
        end
        // funct3[1:0] encodes width for both loads and stores: 01 half, 10 word.
        misalign = CHECK_ALIGN &&
                   (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                    ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)));
        accept   = req && f3_legal && !misalign;
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rd_d        = rd_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        wb_data_d   = wb_data_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (req && !f3_legal) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_FUNCT3;
                    err_addr_d  = ex_addr;
                end else if (req && misalign) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_MISALIGN;
                    err_addr_d  = ex_addr;
                end else if (accept) begin
                    is_load_d = req_load;
                    funct3_d  = ex_funct3;
                    addr_d    = ex_addr;
                    data_d    = ex_store_data;
                    rd_d      = ex_rd;
                    rd_en_d   = req_load;
                    wr_en_d   = !req_load;
                    cnt_d     = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                kill_d  = kill_q || flush;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                kill_d = kill_q || flush;
                // The first WAIT cycle is ignored: data_memory raises busy one cycle late.
                if ((cnt_q != '0) && !mem_busy) begin
                    wb_data_d = mem_data_out;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    err_addr_d  = addr_q;
                    kill_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            data_q      <= 32'h0;
            rd_q        <= 5'd0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            wb_data_q   <= 32'h0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            wb_data_q   <= wb_data_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;
    assign load_type    = funct3_q;
    assign store_type   = funct3_q;
    assign ram_address  = addr_q;
    assign data_in      = data_q;
    assign stall_req    = accept || (state_q != S_IDLE);
    // A flush arriving in DONE itself still squashes the writeback.
    assign wb_valid     = (state_q == S_DONE) && is_load_q && !kill_q && !flush;
    assign wb_rd        = rd_q;
    assign wb_data      = wb_data_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign err_addr     = err_addr_q;
    assign dbg_state    = state_q;

endmodule
